regfile_write_arbiter: RTL and testbench

Owns the single write port of the 32x32 register file and shares it between two writeback sources: ALU (port A) and load unit (port B). Tracks in-flight destination registers in a busy scoreboard. Decode uses the scoreboard for RAW stalls and WAW issue blocking. Sits between execute/memory writeback and the register file write inputs.

---
 rtl/regfile_write_arbiter.sv | 93 +++++++++
 tb/tb_regfile_write_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: arbitrates ALU/load writebacks onto the single register file write port and keeps the busy scoreboard.
// Optional macro WRITE_BYPASS_EN adds forwarding outputs and makes busy clears visible combinationally.
module regfile_write_arbiter #(
  parameter int XLEN         = 32,
  parameter int NUM_REGS     = 32,
  parameter int STARVE_LIMIT = 3
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            a_valid,
  input  logic [4:0]      a_rd,
  input  logic [XLEN-1:0] a_data,
  output logic            a_ready,
  input  logic            b_valid,
  input  logic [4:0]      b_rd,
  input  logic [XLEN-1:0] b_data,
  output logic            b_ready,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  output logic            issue_ready,
  input  logic [4:0]      rs1_idx,
  input  logic [4:0]      rs2_idx,
  output logic            rs1_busy,
  output logic            rs2_busy,
`ifdef WRITE_BYPASS_EN
  output logic            rs1_fwd_valid,
  output logic [XLEN-1:0] rs1_fwd_data,
  output logic            rs2_fwd_valid,
  output logic [XLEN-1:0] rs2_fwd_data,
`endif
  output logic [4:0]      register_write,
  output logic [XLEN-1:0] write_data,
  output logic            register_write_enable
);
  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);
  logic                grant_a, grant_b, accept;
  logic [4:0]          acc_rd;
  logic [XLEN-1:0]     acc_data;
  logic [3:0]          starve_q, starve_d;
  logic [NUM_REGS-1:0] busy_q, busy_d, clr, set, busy_v;
  logic [4:0]          wr_q, wr_d;
  logic [XLEN-1:0]     wd_q, wd_d;
  logic                we_q, we_d;
  always_comb begin
    grant_a     = reset_n && a_valid && (!b_valid || starve_q == LIMIT);
    grant_b     = reset_n && b_valid && !grant_a;
    accept      = grant_a || grant_b;
    acc_rd      = grant_a ? a_rd : b_rd;
    acc_data    = grant_a ? a_data : b_data;
    starve_d    = (a_valid && !grant_a) ? starve_q + {3'b0, starve_q != 4'd15} : 4'd0;
    clr         = accept ? NUM_REGS'(1) << acc_rd : '0;
    issue_ready = issue_rd == 5'd0 || !busy_q[issue_rd] || (accept && acc_rd == issue_rd);
    set         = (issue_valid && issue_ready) ? NUM_REGS'(1) << issue_rd : '0;
    // set applied after clear so a same-cycle reissue keeps the register busy
    busy_d      = ((busy_q & ~clr) | set) & ~NUM_REGS'(1);
    we_d        = accept && acc_rd != 5'd0;
    wr_d        = we_d ? acc_rd : wr_q;
    wd_d        = we_d ? acc_data : wd_q;
`ifdef WRITE_BYPASS_EN
    busy_v      = busy_q & ~clr;
`else
    busy_v      = busy_q;
`endif
  end
  assign a_ready               = grant_a;
  assign b_ready               = grant_b;
  assign rs1_busy              = busy_v[rs1_idx];
  assign rs2_busy              = busy_v[rs2_idx];
  assign register_write        = wr_q;
  assign write_data            = wd_q;
  assign register_write_enable = we_q;
`ifdef WRITE_BYPASS_EN
  assign rs1_fwd_valid = we_q && wr_q == rs1_idx && rs1_idx != 5'd0;
  assign rs2_fwd_valid = we_q && wr_q == rs2_idx && rs2_idx != 5'd0;
  assign rs1_fwd_data  = wd_q;
  assign rs2_fwd_data  = wd_q;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q <= '0;
      busy_q   <= '0;
      wr_q     <= '0;
      wd_q     <= '0;
      we_q     <= 1'b0;
    end else begin
      starve_q <= starve_d;
      busy_q   <= busy_d;
      wr_q     <= wr_d;
      wd_q     <= wd_d;
      we_q     <= we_d;
    end
  end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of arbitration, latency, x0 handling, scoreboard and async reset.
module tb_regfile_write_arbiter;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        a_valid, b_valid, issue_valid;
  logic [4:0]  a_rd, b_rd, issue_rd, rs1_idx, rs2_idx;
  logic [31:0] a_data, b_data;
  logic        a_ready, b_ready, issue_ready, rs1_busy, rs2_busy;
  logic [4:0]  register_write;
  logic [31:0] write_data;
  logic        register_write_enable;
`ifdef WRITE_BYPASS_EN
  logic        rs1_fwd_valid, rs2_fwd_valid;
  logic [31:0] rs1_fwd_data, rs2_fwd_data;
`endif
  int errors = 0;
  int checks = 0;
  logic [7:0] pat = 8'b1000_1000;

  always #5 clk = ~clk;

  regfile_write_arbiter dut (
    .clk(clk), .reset_n(reset_n),
    .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_rd(b_rd), .b_data(b_data), .b_ready(b_ready),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .rs1_idx(rs1_idx), .rs2_idx(rs2_idx), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
`ifdef WRITE_BYPASS_EN
    .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data),
`endif
    .register_write(register_write), .write_data(write_data),
    .register_write_enable(register_write_enable)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1; issue_valid = 1'b0;
    a_rd = 5'd1; b_rd = 5'd2; a_data = '0; b_data = '0;
    issue_rd = '0; rs1_idx = '0; rs2_idx = '0;
    #3;
    chk("rst_a_ready", a_ready, 0);
    chk("rst_b_ready", b_ready, 0);
    chk("rst_we", register_write_enable, 0);
    chk("rst_rw", register_write, 0);
    chk("rst_wd", write_data, 0);
    @(negedge clk);
    reset_n = 1'b1; b_valid = 1'b0;
    a_rd = 5'd5; a_data = 32'h1234;
    #1;
    chk("single_a_ready", a_ready, 1);
    chk("single_b_ready", b_ready, 0);
    @(negedge clk);
    a_valid = 1'b0;
    chk("single_we", register_write_enable, 1);
    chk("single_rw", register_write, 5);
    chk("single_wd", write_data, 32'h1234);
    @(negedge clk);
    chk("single_we_off", register_write_enable, 0);
    chk("single_rw_hold", register_write, 5);
    chk("single_wd_hold", write_data, 32'h1234);
    a_valid = 1'b1; b_valid = 1'b1; a_rd = 5'd10; b_rd = 5'd11;
    a_data = 32'hA00; b_data = 32'hB00;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk($sformatf("arb_a_ready%0d", i), a_ready, pat[i]);
      chk($sformatf("arb_b_ready%0d", i), b_ready, !pat[i]);
      @(negedge clk);
      chk($sformatf("arb_we%0d", i), register_write_enable, 1);
      chk($sformatf("arb_rw%0d", i), register_write, pat[i] ? 10 : 11);
      chk($sformatf("arb_wd%0d", i), write_data, pat[i] ? a_data : b_data);
      if (pat[i]) a_data = a_data + 1;
      else b_data = b_data + 1;
    end
    chk("arb_a_count", a_data, 32'hA02);
    chk("arb_b_count", b_data, 32'hB06);
    a_valid = 1'b0;
    b_rd = 5'd0; b_data = 32'hFFFF_FFFF; rs1_idx = 5'd0;
    #1;
    chk("x0_b_ready", b_ready, 1);
    chk("x0_rs1_busy", rs1_busy, 0);
    @(negedge clk);
    b_valid = 1'b0;
    chk("x0_we", register_write_enable, 0);
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1;
    chk("issue7_ready", issue_ready, 1);
    @(negedge clk);
    issue_valid = 1'b0; rs1_idx = 5'd7; rs2_idx = 5'd7;
    #1;
    chk("busy7_rs1", rs1_busy, 1);
    chk("busy7_rs2", rs2_busy, 1);
    issue_valid = 1'b1;
    #1;
    chk("waw_block", issue_ready, 0);
    a_valid = 1'b1; a_rd = 5'd7; a_data = 32'h77;
    #1;
    chk("wb7_a_ready", a_ready, 1);
    chk("wb7_issue_ready", issue_ready, 1);
    @(negedge clk);
    a_valid = 1'b0; issue_valid = 1'b0;
    chk("setwins_busy", rs1_busy, 1);
    chk("wb7_we", register_write_enable, 1);
    chk("wb7_rw", register_write, 7);
    b_valid = 1'b1; b_rd = 5'd7; b_data = 32'h707;
    @(negedge clk);
    b_valid = 1'b0;
    chk("clear7_busy", rs1_busy, 0);
    chk("clear7_wd", write_data, 32'h707);
    issue_valid = 1'b1; issue_rd = 5'd3;
    @(negedge clk);
    issue_rd = 5'd9;
    @(negedge clk);
    issue_valid = 1'b0; rs1_idx = 5'd3; rs2_idx = 5'd9;
    a_valid = 1'b1; a_rd = 5'd12; a_data = 32'h55;
    #1;
    chk("pre_rst_busy3", rs1_busy, 1);
    chk("pre_rst_busy9", rs2_busy, 1);
    @(posedge clk);
    #1;
    chk("pre_rst_we", register_write_enable, 1);
    #1 reset_n = 1'b0;
    #1;
    chk("mid_rst_we", register_write_enable, 0);
    chk("mid_rst_busy3", rs1_busy, 0);
    chk("mid_rst_busy9", rs2_busy, 0);
    chk("mid_rst_a_ready", a_ready, 0);
    @(negedge clk);
    reset_n = 1'b1; a_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_we", register_write_enable, 0);
    chk("post_rst_rw", register_write, 0);
`ifdef WRITE_BYPASS_EN
    a_valid = 1'b1; a_rd = 5'd4; a_data = 32'hABCD; rs2_idx = 5'd4;
    @(negedge clk);
    a_valid = 1'b0;
    chk("fwd_valid", rs2_fwd_valid, 1);
    chk("fwd_data", rs2_fwd_data, 32'hABCD);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
